prog_mem: RTL

//   Parametrised multi-read-port program/data memory with byte-enable write and a built-in

---
 rtl/prog_mem.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/prog_mem.sv
// Multi-read-port program/data memory with byte-enable external writes and a
// serial byte loader that assembles little-endian words and writes them in order.
module prog_mem #(
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 4096,
  parameter  int RD_PORTS = 2,
  localparam int NB       = DATA_W / 8,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [NB-1:0]              wr_be_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic [RD_PORTS-1:0]        rd_en_i,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr_i,
  output logic [RD_PORTS*DATA_W-1:0] rd_data_o,
  input  logic                       ld_start_i,
  input  logic [ADDR_W-1:0]          ld_base_i,
  input  logic [IDX_W:0]             ld_len_i,
  input  logic [7:0]                 ld_byte_i,
  input  logic                       ld_valid_i,
  output logic                       ld_ready_o,
  output logic                       ld_busy_o,
  output logic                       ld_done_o
);

  localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 0;
  localparam int BCNT_W = (BYTE_W > 0) ? BYTE_W : 1;
  localparam logic [BCNT_W-1:0] BLAST   = BCNT_W'(NB - 1);
  localparam logic [BCNT_W-1:0] BONE    = BCNT_W'(1);
  localparam logic [IDX_W:0]    REM_ONE = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0]  PTR_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [IDX_W-1:0]   rd_idx_p1 [RD_PORTS];

  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W:0]     remaining;
  logic [BCNT_W-1:0]  bcnt;
  logic [DATA_W-1:0]  asm_word;
  logic [DATA_W-1:0]  ld_word;
  logic               accept;
  logic               last_byte;
  logic               unused_addr_bits;

  // Only the word-index field of each address matters; the rest wraps away.
  assign unused_addr_bits = ^{wr_addr_i, ld_base_i, rd_addr_i};

  assign wr_idx    = wr_addr_i[BYTE_W +: IDX_W];
  assign accept    = (state == LOAD) && ld_valid_i;
  assign last_byte = accept && (bcnt == BLAST);

  // Completed word: bytes gathered so far plus the byte arriving this cycle.
  always_comb begin
    ld_word = asm_word;
    ld_word[8*bcnt +: 8] = ld_byte_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_ready_o = 1'b0;
    ld_busy_o  = 1'b0;
    ld_done_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld_start_i) begin
          state_nxt = (ld_len_i != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        ld_ready_o = 1'b1;
        ld_busy_o  = 1'b1;
        if (last_byte && (remaining == REM_ONE)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ld_done_o = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      bcnt      <= '0;
    end else if ((state == IDLE) && ld_start_i) begin
      ptr       <= ld_base_i[BYTE_W +: IDX_W];
      remaining <= ld_len_i;
      bcnt      <= '0;
    end else if (accept) begin
      if (last_byte) begin
        bcnt      <= '0;
        ptr       <= ptr + PTR_ONE;
        remaining <= remaining - REM_ONE;
      end else begin
        bcnt <= bcnt + BONE;
      end
    end
  end

  // Assembly buffer is pure data; a fresh load restarts at byte 0 via bcnt.
  always_ff @(posedge clk) begin
    if (accept) begin
      asm_word[8*bcnt +: 8] <= ld_byte_i;
    end
  end

  // Loader owns the array while busy, so a colliding external write is dropped.
  always_ff @(posedge clk) begin
    if (last_byte) begin
      mem[ptr] <= ld_word;
    end else if (wr_en_i && !ld_busy_o) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be_i[k]) begin
          mem[wr_idx][8*k +: 8] <= wr_data_i[8*k +: 8];
        end
      end
    end
  end

  // ---- stage p1: captured read indices; array lookup is combinational after
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < RD_PORTS; p++) begin
        rd_idx_p1[p] <= '0;
      end
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        if (rd_en_i[p]) begin
          rd_idx_p1[p] <= rd_addr_i[p*ADDR_W + BYTE_W +: IDX_W];
        end
      end
    end
  end

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    assign rd_data_o[g*DATA_W +: DATA_W] = mem[rd_idx_p1[g]];
  end

endmodule
